// File: rtl/led_display_pkg.sv
// Shared types, segment bit positions, hex glyphs and the PWM on-time helper
// for the multiplexed 7-segment scan driver.
package led_display_pkg;

   typedef logic [7:0] seg_t;

   localparam int SEG_A  = 7;
   localparam int SEG_B  = 6;
   localparam int SEG_C  = 5;
   localparam int SEG_D  = 4;
   localparam int SEG_E  = 3;
   localparam int SEG_F  = 2;
   localparam int SEG_G  = 1;
   localparam int SEG_DP = 0;

   localparam seg_t SEG_BLANK = 8'h00;

   localparam seg_t HEX_0 = 8'hFC;
   localparam seg_t HEX_1 = 8'h60;
   localparam seg_t HEX_2 = 8'hDA;
   localparam seg_t HEX_3 = 8'hF2;
   localparam seg_t HEX_4 = 8'h66;
   localparam seg_t HEX_5 = 8'hB6;
   localparam seg_t HEX_6 = 8'hBE;
   localparam seg_t HEX_7 = 8'hE0;
   localparam seg_t HEX_8 = 8'hFE;
   localparam seg_t HEX_9 = 8'hF6;
   localparam seg_t HEX_A = 8'hEE;
   localparam seg_t HEX_B = 8'h3E;
   localparam seg_t HEX_C = 8'h9C;
   localparam seg_t HEX_D = 8'h7A;
   localparam seg_t HEX_E = 8'h9E;
   localparam seg_t HEX_F = 8'h8E;

   // Full code gets the whole active window so maximum brightness has no gap.
   function automatic logic [31:0] calc_on_len(input logic [31:0] active,
                                               input logic [31:0] code,
                                               input int unsigned bw);
      logic [31:0] maxb;
      logic [63:0] prod;
      logic [63:0] shifted;
      maxb    = (32'd1 << bw) - 32'd1;
      prod    = {32'd0, active} * {32'd0, code};
      shifted = prod >> bw;
      if (code == maxb) begin
         return active;
      end else begin
         return shifted[31:0];
      end
   endfunction

endpackage

// File: rtl/led_scan_timer.sv
// Slot/digit scan counters, frame boundary detection, frame tick and the
// blink phase generator. Everything is held at zero while en is low.
module led_scan_timer #(
   parameter int NUM          = 4,
   parameter int CLK_CYCLE    = 1000,
   parameter int BLINK_FRAMES = 64,
   parameter int SLOT_W       = $clog2(CLK_CYCLE),
   parameter int DIG_W        = (NUM > 1) ? $clog2(NUM) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   output logic [SLOT_W-1:0] slot_cnt,
   output logic [DIG_W-1:0]  dig_idx,
   output logic              boundary,
   output logic              frame_tick,
   output logic              blink_phase
);

   localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [SLOT_W-1:0] slot_cnt_r;
   logic [DIG_W-1:0]  dig_idx_r;
   logic [FRM_W-1:0]  frame_cnt_r;
   logic              blink_phase_r;
   logic              frame_tick_r;
   logic              slot_wrap_s;
   logic              dig_wrap_s;
   logic              frame_wrap_s;
   logic              boundary_s;

   // Wrap and boundary decode from the current counter state.
   always_comb begin
      slot_wrap_s  = (slot_cnt_r == SLOT_W'(CLK_CYCLE - 32'd1));
      dig_wrap_s   = (dig_idx_r == DIG_W'(NUM - 32'd1));
      frame_wrap_s = (frame_cnt_r == FRM_W'(BLINK_FRAMES - 32'd1));
      boundary_s   = en & (slot_cnt_r == {SLOT_W{1'b0}}) & (dig_idx_r == {DIG_W{1'b0}});
   end

   // Slot and digit counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_cnt_r <= {SLOT_W{1'b0}};
         dig_idx_r  <= {DIG_W{1'b0}};
      end else if (!en) begin
         slot_cnt_r <= {SLOT_W{1'b0}};
         dig_idx_r  <= {DIG_W{1'b0}};
      end else if (slot_wrap_s) begin
         slot_cnt_r <= {SLOT_W{1'b0}};
         dig_idx_r  <= dig_wrap_s ? {DIG_W{1'b0}} : dig_idx_r + DIG_W'(1'b1);
      end else begin
         slot_cnt_r <= slot_cnt_r + SLOT_W'(1'b1);
      end
   end

   // Frame tick is registered so it lines up with the registered pins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt_r   <= {FRM_W{1'b0}};
         blink_phase_r <= 1'b0;
         frame_tick_r  <= 1'b0;
      end else if (!en) begin
         frame_cnt_r   <= {FRM_W{1'b0}};
         blink_phase_r <= 1'b0;
         frame_tick_r  <= 1'b0;
      end else begin
         frame_tick_r <= boundary_s;
         if (boundary_s) begin
            if (frame_wrap_s) begin
               frame_cnt_r   <= {FRM_W{1'b0}};
               blink_phase_r <= ~blink_phase_r;
            end else begin
               frame_cnt_r <= frame_cnt_r + FRM_W'(1'b1);
            end
         end
      end
   end

   assign slot_cnt    = slot_cnt_r;
   assign dig_idx     = dig_idx_r;
   assign boundary    = boundary_s;
   assign frame_tick  = frame_tick_r;
   assign blink_phase = blink_phase_r;

endmodule

// File: rtl/led_display_scan_ctrl.sv
// Multiplexed 7-segment scan driver with per-digit PWM brightness, blink,
// dead-time blanking and a tear-free double-buffered frame update port.
module led_display_scan_ctrl
   import led_display_pkg::*;
#(
   parameter int   NUM          = 4,
   parameter logic VALID_SIGNAL = 1'b0,
   parameter int   CLK_CYCLE    = 1000,
   parameter int   DEAD_CYCLE   = 16,
   parameter int   BRIGHT_W     = 4,
   parameter int   BLINK_FRAMES = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [NUM*8-1:0]        seg_in,
   input  logic [NUM*BRIGHT_W-1:0] bright_in,
   input  logic [NUM-1:0]          blink_in,
   input  logic                    upd_valid,
   output logic                    upd_ready,
   output logic                    frame_tick,
   output logic [7:0]              led_display_seg,
   output logic [NUM-1:0]          led_display_sel
);

   localparam int SLOT_W = $clog2(CLK_CYCLE);
   localparam int DIG_W  = (NUM > 1) ? $clog2(NUM) : 1;
   localparam int ACTIVE = CLK_CYCLE - DEAD_CYCLE;

   seg_t                pend_seg_r    [NUM];
   logic [BRIGHT_W-1:0] pend_bright_r [NUM];
   logic [NUM-1:0]      pend_blink_r;
   logic                pend_full_r;
   seg_t                act_seg_r     [NUM];
   logic [BRIGHT_W-1:0] act_bright_r  [NUM];
   logic [NUM-1:0]      act_blink_r;
   logic [7:0]          seg_r;
   logic [NUM-1:0]      sel_r;

   logic [SLOT_W-1:0]   slot_cnt_s;
   logic [DIG_W-1:0]    dig_idx_s;
   logic                boundary_s;
   logic                blink_phase_s;
   logic                xfer_s;
   logic                apply_s;
   seg_t                cur_seg_s;
   logic [BRIGHT_W-1:0] cur_bright_s;
   logic                cur_blink_s;
   logic [31:0]         on_len_s;
   logic                lit_s;
   logic [7:0]          seg_nxt_s;
   logic [NUM-1:0]      sel_nxt_s;

   led_scan_timer #(
      .NUM          (NUM),
      .CLK_CYCLE    (CLK_CYCLE),
      .BLINK_FRAMES (BLINK_FRAMES),
      .SLOT_W       (SLOT_W),
      .DIG_W        (DIG_W)
   ) u_timer (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .slot_cnt    (slot_cnt_s),
      .dig_idx     (dig_idx_s),
      .boundary    (boundary_s),
      .frame_tick  (frame_tick),
      .blink_phase (blink_phase_s)
   );

   // Handshake, current-digit lookup and lit window decode.
   always_comb begin
      xfer_s       = upd_valid & ~pend_full_r;
      apply_s      = boundary_s & pend_full_r;
      cur_seg_s    = act_seg_r[dig_idx_s];
      cur_bright_s = act_bright_r[dig_idx_s];
      cur_blink_s  = act_blink_r[dig_idx_s];
      on_len_s     = calc_on_len(32'(ACTIVE), 32'(cur_bright_s), BRIGHT_W);
      lit_s        = en
                   & (32'(slot_cnt_s) >= 32'(DEAD_CYCLE))
                   & (32'(slot_cnt_s) < (32'(DEAD_CYCLE) + on_len_s))
                   & ~(cur_blink_s & blink_phase_s);
   end

   // Next pin levels; a single select bit can be active at a time.
   always_comb begin
      seg_nxt_s = {8{~VALID_SIGNAL}};
      sel_nxt_s = {NUM{~VALID_SIGNAL}};
      if (lit_s) begin
         seg_nxt_s            = cur_seg_s ^ {8{~VALID_SIGNAL}};
         sel_nxt_s[dig_idx_s] = VALID_SIGNAL;
      end else begin
         seg_nxt_s = {8{~VALID_SIGNAL}};
         sel_nxt_s = {NUM{~VALID_SIGNAL}};
      end
   end

   // Pending buffer fills on a transfer; active copy only changes at a boundary.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_full_r  <= 1'b0;
         pend_blink_r <= {NUM{1'b0}};
         act_blink_r  <= {NUM{1'b0}};
         for (int i = 0; i < NUM; i++) begin
            pend_seg_r[i]    <= SEG_BLANK;
            pend_bright_r[i] <= {BRIGHT_W{1'b0}};
            act_seg_r[i]     <= SEG_BLANK;
            act_bright_r[i]  <= {BRIGHT_W{1'b0}};
         end
      end else begin
         if (xfer_s) begin
            pend_full_r  <= 1'b1;
            pend_blink_r <= blink_in;
            for (int i = 0; i < NUM; i++) begin
               pend_seg_r[i]    <= seg_in[i*8 +: 8];
               pend_bright_r[i] <= bright_in[i*BRIGHT_W +: BRIGHT_W];
            end
         end else if (apply_s) begin
            pend_full_r <= 1'b0;
         end
         if (apply_s) begin
            act_blink_r <= pend_blink_r;
            for (int i = 0; i < NUM; i++) begin
               act_seg_r[i]    <= pend_seg_r[i];
               act_bright_r[i] <= pend_bright_r[i];
            end
         end
      end
   end

   // Pin-level output register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_r <= {8{~VALID_SIGNAL}};
         sel_r <= {NUM{~VALID_SIGNAL}};
      end else begin
         seg_r <= seg_nxt_s;
         sel_r <= sel_nxt_s;
      end
   end

   assign upd_ready       = ~pend_full_r;
   assign led_display_seg = seg_r;
   assign led_display_sel = sel_r;

endmodule

// File: tb/tb_led_display_scan_ctrl.sv
// Directed self-checking bench for led_display_scan_ctrl with a 20-cycle slot,
// 4 dead cycles and a 2-frame blink half-period.
module tb_led_display_scan_ctrl;

   localparam int NUM        = 4;
   localparam int CLK_CYCLE  = 20;
   localparam int DEAD_CYCLE = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [31:0] seg_in;
   logic [15:0] bright_in;
   logic [3:0]  blink_in;
   logic        upd_valid;
   logic        upd_ready;
   logic        frame_tick;
   logic [7:0]  led_display_seg;
   logic [3:0]  led_display_sel;

   int err_cnt = 0;
   int chk_cnt = 0;
   int fnum    = 0;
   int cap_k   = -1;
   int tick_cnt;

   logic [31:0] mdl_act_seg, mdl_pend_seg;
   logic [15:0] mdl_act_bright, mdl_pend_bright;
   logic [3:0]  mdl_act_blink, mdl_pend_blink;
   logic        mdl_pend_full;

   logic [31:0] q_seg [$];
   logic [15:0] q_bright [$];
   logic [3:0]  q_blink [$];

   always #5 clk = ~clk;

   led_display_scan_ctrl #(
      .NUM          (NUM),
      .VALID_SIGNAL (1'b0),
      .CLK_CYCLE    (CLK_CYCLE),
      .DEAD_CYCLE   (DEAD_CYCLE),
      .BRIGHT_W     (4),
      .BLINK_FRAMES (2)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .en              (en),
      .seg_in          (seg_in),
      .bright_in       (bright_in),
      .blink_in        (blink_in),
      .upd_valid       (upd_valid),
      .upd_ready       (upd_ready),
      .frame_tick      (frame_tick),
      .led_display_seg (led_display_seg),
      .led_display_sel (led_display_sel)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_frame(input logic [31:0] s, input logic [15:0] b, input logic [3:0] k);
      q_seg.push_back(s);
      q_bright.push_back(b);
      q_blink.push_back(k);
   endtask

   // Expected {frame_tick, sel, seg} for frame cycle k (active-low pins).
   function automatic logic [12:0] exp_pins(input int k);
      int         d, s, len;
      logic [3:0] b;
      logic [3:0] sel;
      logic [7:0] pat;
      logic       ph, lit;
      d   = k / CLK_CYCLE;
      s   = k % CLK_CYCLE;
      b   = mdl_act_bright[d*4 +: 4];
      len = (b == 4'd15) ? 16 : int'(b);
      ph  = ((fnum / 2) % 2) == 1;
      lit = (s >= DEAD_CYCLE) && (s < DEAD_CYCLE + len) && !(mdl_act_blink[d] && ph);
      pat = mdl_act_seg[d*8 +: 8];
      sel = 4'hF;
      sel[d] = 1'b0;
      if (lit) return {(k == 0), sel, ~pat};
      return {(k == 0), 4'hF, 8'hFF};
   endfunction

   // Checks ncyc cycles starting at the frame_tick sample, driving queued offers.
   task automatic run_frame(input int ncyc, input int offer_k);
      logic xfer;
      fnum++;
      if (mdl_pend_full) begin
         mdl_act_seg    = mdl_pend_seg;
         mdl_act_bright = mdl_pend_bright;
         mdl_act_blink  = mdl_pend_blink;
         mdl_pend_full  = 1'b0;
      end
      for (int k = 0; k < ncyc; k++) begin
         check_val($sformatf("pins_f%0d_k%0d", fnum, k),
                   {19'd0, frame_tick, led_display_sel, led_display_seg}, {19'd0, exp_pins(k)});
         if (!upd_valid && q_seg.size() > 0 && k >= offer_k) begin
            seg_in    = q_seg[0];
            bright_in = q_bright[0];
            blink_in  = q_blink[0];
            upd_valid = 1'b1;
         end
         xfer = upd_valid && upd_ready;
         tick();
         if (xfer) begin
            mdl_pend_seg    = seg_in;
            mdl_pend_bright = bright_in;
            mdl_pend_blink  = blink_in;
            mdl_pend_full   = 1'b1;
            void'(q_seg.pop_front());
            void'(q_bright.pop_front());
            void'(q_blink.pop_front());
            upd_valid = 1'b0;
            cap_k     = k + 1;
            check_val("rdy_drop", {31'd0, upd_ready}, 32'd0);
         end
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; upd_valid = 1'b0;
      seg_in = 32'd0; bright_in = 16'd0; blink_in = 4'd0;
      mdl_act_seg = 32'd0; mdl_act_bright = 16'd0; mdl_act_blink = 4'd0;
      mdl_pend_seg = 32'd0; mdl_pend_bright = 16'd0; mdl_pend_blink = 4'd0;
      mdl_pend_full = 1'b0;

      // 1. Reset state; an offer during reset must be ignored.
      tick();
      seg_in = 32'h12345678; bright_in = 16'hFFFF; upd_valid = 1'b1;
      tick(); tick();
      check_val("rst_seg",   {24'd0, led_display_seg}, 32'hFF);
      check_val("rst_sel",   {28'd0, led_display_sel}, 32'hF);
      check_val("rst_ready", {31'd0, upd_ready}, 32'd1);
      check_val("rst_tick",  {31'd0, frame_tick}, 32'd0);
      upd_valid = 1'b0;
      tick();
      rst = 1'b0;
      tick_cnt = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (frame_tick) tick_cnt++;
         check_val("idle_pins", {20'd0, led_display_sel, led_display_seg}, 32'hFFF);
      end
      check_val("idle_ticks", tick_cnt, 32'd0);

      // 2. Frame A loaded while idle, then scanning starts.
      seg_in = 32'hF2DA60FC; bright_in = 16'hFFFF; blink_in = 4'b0000; upd_valid = 1'b1;
      check_val("idle_rdy", {31'd0, upd_ready}, 32'd1);
      tick();
      upd_valid = 1'b0;
      mdl_pend_seg = seg_in; mdl_pend_bright = bright_in; mdl_pend_blink = blink_in;
      mdl_pend_full = 1'b1;
      check_val("idle_full", {31'd0, upd_ready}, 32'd0);
      en = 1'b1;
      tick();

      // 3. Same glyphs with digit1 at half brightness and digit2 dark.
      push_frame(32'hF2DA60FC, 16'hF08F, 4'b0000);
      run_frame(80, 2);
      check_val("capA2_k", cap_k, 32'd3);

      // 4. Frame B then C back to back: C must wait for the boundary.
      push_frame(32'hE0BEB666, 16'hFFFF, 4'b0000);
      push_frame(32'h3EEEF6FE, 16'hFFFF, 4'b0001);
      run_frame(80, 2);
      check_val("capB_k", cap_k, 32'd3);
      check_val("c_held", q_seg.size(), 32'd1);
      run_frame(80, 2);
      check_val("capC_k", cap_k, 32'd1);
      check_val("c_taken", q_seg.size(), 32'd0);

      // 5. Frame C blinks digit 0: lit, lit, dark, dark.
      for (int f = 0; f < 4; f++) run_frame(80, 0);

      // 6. Reset during digit 2's lit window with frame D pending.
      push_frame(32'h9C7A9E8E, 16'hFFFF, 4'b0000);
      run_frame(46, 2);
      check_val("pre_rst_sel", {28'd0, led_display_sel}, 32'hB);
      check_val("pre_rst_seg", {24'd0, led_display_seg}, 32'h11);
      check_val("pre_rst_rdy", {31'd0, upd_ready}, 32'd0);
      rst = 1'b1;
      #1;
      check_val("mid_rst_seg",   {24'd0, led_display_seg}, 32'hFF);
      check_val("mid_rst_sel",   {28'd0, led_display_sel}, 32'hF);
      check_val("mid_rst_ready", {31'd0, upd_ready}, 32'd1);
      check_val("mid_rst_tick",  {31'd0, frame_tick}, 32'd0);
      tick(); tick();
      rst = 1'b0;
      mdl_act_seg = 32'd0; mdl_act_bright = 16'd0; mdl_act_blink = 4'd0;
      mdl_pend_full = 1'b0;
      fnum = 0;
      tick();
      run_frame(80, 0);
      check_val("post_rst_ready", {31'd0, upd_ready}, 32'd1);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
